// File: rtl/regfile_reader.sv
// Burst reader: streams a run of regfile words out through a small credit-limited FIFO.
// Each beat carries the word's data, its source address and a last-beat flag.
module regfile_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  ran_re,
  output logic [ADDR_WIDTH-1:0] ran_r_addr,
  input  logic [DATA_WIDTH-1:0] ran_r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing regfile reads as FIFO credit allows
  // DRAIN | all reads issued, waiting for the last beat to leave
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;
  logic                  infl_last_q, infl_last_d;
  logic                  done_q, done_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];

  logic issue, credit_ok, wr_en, rd_en, last_xfer, abort_acc, flush;

  // Outputs are gated by m_valid so an empty FIFO presents zeros, including under reset.
  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_addr     = m_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign m_last     = m_valid && fifo_last_q[rd_ptr_q];
  assign busy       = (state_q != IDLE);
  assign rd_en      = m_valid && m_ready;
  assign wr_en      = inflight_q;
  assign last_xfer  = (state_q == DRAIN) && rd_en && m_last;
  // A completing last beat takes precedence over a simultaneous abort.
  assign abort_acc  = abort && busy && !last_xfer;
  assign credit_ok  = ({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = (state_q == READ) && (remain_q != '0) && credit_ok && !abort;
  assign ran_re     = issue;
  assign ran_r_addr = addr_q;
  assign done       = done_q || last_xfer;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    inflight_d  = issue;
    infl_addr_d = issue ? addr_q : infl_addr_q;
    infl_last_d = issue ? (remain_q == (ADDR_WIDTH+1)'(1)) : infl_last_q;
    done_d      = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d   = base_addr;
            remain_d = length;
            state_d  = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (abort_acc) begin
          state_d = IDLE;
          flush   = 1'b1;
          done_d  = 1'b1;
        end else if (issue) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - (ADDR_WIDTH+1)'(1);
          if (remain_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_acc) begin
          state_d = IDLE;
          flush   = 1'b1;
          done_d  = 1'b1;
        end else if (last_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data_q[wr_ptr_q] <= ran_r_data;
      fifo_addr_q[wr_ptr_q] <= infl_addr_q;
      fifo_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

endmodule
